seq_gen_101_110_moore: RTL

SEQ_GEN_101_110_MOORE -- requirements
Module: seq_gen_101_110_moore

---
 rtl/seq_gen_pkg.sv | 23 ++
 rtl/seq_gen_101_110_moore_if.sv | 27 ++
 rtl/seq_gen_rep_cnt.sv | 27 ++
 rtl/seq_gen_101_110_moore.sv | 110 +++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - shared types and constants for the 101/110 Moore sequence generator
package seq_gen_pkg;

    localparam int MAX_REPS_DEFAULT = 16;

    localparam logic [2:0] PAT_101 = 3'b101;
    localparam logic [2:0] PAT_110 = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIT2  = 3'd1,
        ST_BIT1  = 3'd2,
`ifdef SEQ_GEN_GUARD_EN
        ST_GUARD = 3'd4,
`endif
        ST_BIT0  = 3'd3
    } state_t;

    function automatic logic [2:0] pattern_of(input logic sel);
        return sel ? PAT_110 : PAT_101;
    endfunction

endpackage

// File: rtl/seq_gen_101_110_moore_if.sv
// rtl/seq_gen_101_110_moore_if.sv - burst request / serial stream bundle of the sequence generator
interface seq_gen_101_110_moore_if
    import seq_gen_pkg::*;
#(
    parameter int MAX_REPS = MAX_REPS_DEFAULT
);
    localparam int W = $clog2(MAX_REPS);

    logic         start;
    logic         sel;
    logic [W-1:0] reps;
    logic         ready;
    logic         out;
    logic         busy;
    logic         done;

    modport master (
        output start, sel, reps,
        input  ready, out, busy, done
    );

    modport slave (
        input  start, sel, reps,
        output ready, out, busy, done
    );

endinterface

// File: rtl/seq_gen_rep_cnt.sv
// rtl/seq_gen_rep_cnt.sv - remaining-pattern down-counter with zero flag
module seq_gen_rep_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // Decrement saturates at zero so the largest burst never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_gen_101_110_moore.sv
// rtl/seq_gen_101_110_moore.sv - Moore burst generator of 101/110 patterns; SEQ_GEN_GUARD_EN adds a guard cycle between patterns
module seq_gen_101_110_moore
    import seq_gen_pkg::*;
#(
    parameter int MAX_REPS = MAX_REPS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_gen_101_110_moore_if.slave bus
);

    localparam int W = $clog2(MAX_REPS);

    state_t       state;
    logic [2:0]   pat;
    logic [2:0]   start_pat;
    logic [W-1:0] cnt;
    logic         cnt_zero;
    logic         accept;
    logic         cnt_dec;

    logic         out_q;
    logic         ready_q;
    logic         busy_q;
    logic         done_q;

    assign start_pat = pattern_of(bus.sel);
    assign accept    = (state == ST_IDLE) && bus.start;
    assign cnt_dec   = (state == ST_BIT0) && !cnt_zero;

    seq_gen_rep_cnt #(.W(W)) u_rep_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (bus.reps),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // Outputs are registered alongside the state they belong to, so they
    // change only on a clock edge (or reset) and never follow the inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pat     <= '0;
            out_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state   <= ST_BIT2;
                        pat     <= start_pat;
                        out_q   <= start_pat[2];
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_BIT2: begin
                    state <= ST_BIT1;
                    out_q <= pat[1];
                end
                ST_BIT1: begin
                    // The count only moves in BIT0, so it already tells whether the coming BIT0 is the last.
                    state  <= ST_BIT0;
                    out_q  <= pat[0];
                    done_q <= cnt_zero;
                end
                ST_BIT0: begin
                    if (cnt_zero) begin
                        state   <= ST_IDLE;
                        out_q   <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
`ifdef SEQ_GEN_GUARD_EN
                        state <= ST_GUARD;
                        out_q <= 1'b0;
`else
                        state <= ST_BIT2;
                        out_q <= pat[2];
`endif
                    end
                end
`ifdef SEQ_GEN_GUARD_EN
                ST_GUARD: begin
                    state <= ST_BIT2;
                    out_q <= pat[2];
                end
`endif
                default: begin
                    state   <= ST_IDLE;
                    out_q   <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out   = out_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
